// File: rtl/time_entry.sv
// Keypad time entry and cook sequencer: collects up to four BCD digits,
// loads them into a downstream timer chain, and runs/pauses/finishes the cook cycle.
module time_entry #(
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       start,
  input  logic       stop,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       en,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        loadn_q, en_q, done_q;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      ENTRY: begin
        // priority stop > start > key_valid
        if (stop) begin
          digits_d = 16'h0000;
          cnt_d    = 3'd0;
        end else if (start) begin
          if (digits_q == 16'h0000) begin
            state_d = ENTRY;
          end else if (digits_q[7:4] > 4'(SEC_TENS_MAX)) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (key_valid && (key <= 4'd9) && (cnt_q < 3'd4)) begin
          digits_d = {digits_q[11:0], key};
          cnt_d    = cnt_q + 3'd1;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // timer expiry beats a simultaneous stop
        if (timer_zero) begin
          state_d = DONE;
        end else if (stop) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d  = ENTRY;
          digits_d = 16'h0000;
          cnt_d    = 3'd0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_d  = ENTRY;
          digits_d = 16'h0000;
          cnt_d    = 3'd0;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ENTRY;
      digits_q <= 16'h0000;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
      loadn_q  <= 1'b1;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      loadn_q  <= (state_d != LOAD);
      en_q     <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign min_tens = digits_q[15:12];
  assign min_ones = digits_q[11:8];
  assign sec_tens = digits_q[7:4];
  assign sec_ones = digits_q[3:0];
  assign loadn    = loadn_q;
  assign en       = en_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry; inputs change 1 time unit after the rising edge.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       clr, key_valid, start, stop, timer_zero;
  logic [3:0] key;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, en, done, err;

  int total  = 0;
  int passed = 0;

  time_entry #(.SEC_TENS_MAX(5)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key(key),
    .start(start), .stop(stop), .timer_zero(timer_zero),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .loadn(loadn), .en(en), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    clr = 1'b1; key_valid = 1'b0; key = 4'd0; start = 1'b0; stop = 1'b0; timer_zero = 1'b0;
    tick();
    clr = 1'b0;
    check("rst_digits", digits(), 16'h0000);
    check("rst_loadn", 16'(loadn), 16'h1);
    check("rst_en", 16'(en), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_err", 16'(err), 16'h0);

    // keys 1,3,0 then start -> one-cycle load then run
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_130", digits(), 16'h0130);
    pulse_start();
    check("load_loadn", 16'(loadn), 16'h0);
    check("load_en", 16'(en), 16'h0);
    check("load_digits", digits(), 16'h0130);
    tick();
    check("run_loadn", 16'(loadn), 16'h1);
    check("run_en", 16'(en), 16'h1);

    // pause / resume / cancel
    pulse_stop();
    check("pause_en", 16'(en), 16'h0);
    pulse_start();
    check("resume_en", 16'(en), 16'h1);
    check("resume_loadn", 16'(loadn), 16'h1);
    check("resume_digits", digits(), 16'h0130);
    pulse_stop();
    check("pause2_en", 16'(en), 16'h0);
    pulse_stop();
    check("cancel_digits", digits(), 16'h0000);
    check("cancel_en", 16'(en), 16'h0);
    press(4'd5);
    check("cancel_entry", digits(), 16'h0005);
    pulse_stop();
    check("entry_stop_clr", digits(), 16'h0000);

    // fifth key and non-digit keys ignored
    press(4'hA);
    check("key_A_empty", digits(), 16'h0000);
    press(4'd1); press(4'd2); press(4'hA); press(4'd3); press(4'd4); press(4'd5);
    check("five_keys", digits(), 16'h1234);
    press(4'hF);
    check("key_F_full", digits(), 16'h1234);
    pulse_stop();
    check("clr_1234", digits(), 16'h0000);

    // illegal seconds-tens -> err pulse, stay in entry
    press(4'd0); press(4'd7); press(4'd5);
    pulse_start();
    check("err_pulse", 16'(err), 16'h1);
    check("err_loadn", 16'(loadn), 16'h1);
    check("err_digits", digits(), 16'h0075);
    tick();
    check("err_one_cycle", 16'(err), 16'h0);
    check("err_no_run", 16'(en), 16'h0);
    press(4'd1);
    check("err_still_entry", digits(), 16'h0751);
    pulse_stop();

    // start with all zeros ignored
    pulse_start();
    check("zero_start_loadn", 16'(loadn), 16'h1);
    check("zero_start_err", 16'(err), 16'h0);
    tick();
    check("zero_start_en", 16'(en), 16'h0);

    // boundary: sec_tens == 5 accepted
    press(4'd5); press(4'd9);
    pulse_start();
    check("sec5_loadn", 16'(loadn), 16'h0);
    check("sec5_err", 16'(err), 16'h0);
    tick();
    check("sec5_run", 16'(en), 16'h1);

    // timer_zero with stop -> done; start ignored in done
    timer_zero = 1'b1; stop = 1'b1;
    tick();
    timer_zero = 1'b0; stop = 1'b0;
    check("done_done", 16'(done), 16'h1);
    check("done_en", 16'(en), 16'h0);
    pulse_start();
    check("done_hold", 16'(done), 16'h1);
    check("done_start_en", 16'(en), 16'h0);
    check("done_start_loadn", 16'(loadn), 16'h1);
    pulse_stop();
    check("done_clear", 16'(done), 16'h0);
    check("done_clr_digits", digits(), 16'h0000);

    // priority stop > start > key_valid in entry
    press(4'd1); press(4'd2);
    stop = 1'b1; start = 1'b1; key_valid = 1'b1; key = 4'd9;
    tick();
    stop = 1'b0; start = 1'b0; key_valid = 1'b0;
    check("prio_stop", digits(), 16'h0000);
    check("prio_stop_loadn", 16'(loadn), 16'h1);
    press(4'd1); press(4'd3); press(4'd0);
    start = 1'b1; key_valid = 1'b1; key = 4'd9;
    tick();
    start = 1'b0; key_valid = 1'b0;
    check("prio_start_loadn", 16'(loadn), 16'h0);
    check("prio_start_digits", digits(), 16'h0130);

    // clr in run drops en on the same edge
    tick();
    check("pre_clr_en", 16'(en), 16'h1);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    check("clr_en", 16'(en), 16'h0);
    check("clr_loadn", 16'(loadn), 16'h1);
    check("clr_digits", digits(), 16'h0000);
    press(4'd4);
    check("clr_entry", digits(), 16'h0004);

    // timer_zero ignored during load
    press(4'd1);
    timer_zero = 1'b1;
    pulse_start();
    check("tz_load_loadn", 16'(loadn), 16'h0);
    tick();
    timer_zero = 1'b0;
    check("tz_load_en", 16'(en), 16'h1);
    check("tz_load_done", 16'(done), 16'h0);
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    check("tz_run_done", 16'(done), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
